// File: rtl/vmicro16_ifetch.sv
// Instruction fetch front end: owns the PC, reads a synchronous BRAM, buffers instr+pc for decode.
// Latency: request in cycle t -> out_valid in t+2; branch in t -> target out_valid in t+3.
// Backpressure: out_ready low fills the buffer; issue stops once buffered + in-flight reaches FIFO_DEPTH.
module vmicro16_ifetch #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   br_en,
  input  logic [PC_WIDTH-1:0]    br_target,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   halted
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    inflight_pc;
  logic                   inflight;
  logic                   inflight_kill;
  logic [CW-1:0]          count;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc    [FIFO_DEPTH];

  logic                   deq;
  logic                   enq;
  logic                   redirect;
  logic                   flush;
  logic [CW:0]            occupancy;

  // Head of the buffer; reads zero while empty so decode never sees stale data.
  always_comb begin
    out_valid = (count != '0);
    out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
    out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  end

  // Issue and response control: a request is only made when its response is guaranteed a slot.
  always_comb begin
    deq       = out_valid & out_ready;
    // Branches are ignored once halted; halt wins over a same-cycle branch.
    redirect  = br_en & ~halt & ~halted;
    flush     = halt | redirect;
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    imem_en   = ~reset & ~halted & ~halt & ~br_en & (occupancy < DEPTH_L);
    imem_addr = fetch_pc;
    // A response returning during a flush belongs to the discarded stream.
    enq       = inflight & ~inflight_kill & ~halt & ~br_en;
  end

  // Control state: PC, in-flight tracking, occupancy, pointers and halt latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      inflight_pc   <= RESET_PC;
      inflight      <= 1'b0;
      inflight_kill <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      halted        <= 1'b0;
    end else begin
      inflight      <= imem_en;
      // Any request overlapping a flush must not land in the fresh stream.
      inflight_kill <= flush & imem_en;
      if (imem_en) begin
        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
        inflight_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= br_target;
      end
      if (halt) begin
        halted <= 1'b1;
      end
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Buffer storage: contents are only observable through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_instr[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_vmicro16_ifetch.sv
// Bench for vmicro16_ifetch: BRAM holds mem[a] = 0x1000 + a.
// Reference: the delivered stream is the contiguous PC sequence starting at reset/latest redirect target.
// Randomized out_ready, branch timing and targets are checked against that sequence.
module tb_vmicro16_ifetch;

  logic        clk;
  logic        reset;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        br_en;
  logic [15:0] br_target;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  logic        w_imem_en;
  logic [15:0] w_imem_addr;
  logic [15:0] w_imem_data;
  logic        w_br_en;
  logic [15:0] w_br_target;
  logic        w_halt;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_out_instr;
  logic [15:0] w_out_pc;
  logic        w_halted;

  int          tests;
  int          fails;
  int          cyc;
  logic [15:0] exp_pc;

  vmicro16_ifetch dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .br_en(br_en), .br_target(br_target), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted)
  );

  vmicro16_ifetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .br_en(w_br_en), .br_target(w_br_target), .halt(w_halt),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .halted(w_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction BRAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_data <= 16'h1000 + imem_addr;
    if (w_imem_en) w_imem_data <= 16'h1000 + w_imem_addr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    halt  = 1'b0;
    br_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_pc !== 16'h0) begin
      fails++;
      $display("FAIL reset_out got valid=%b instr=%h pc=%h want 0 0 0", out_valid, out_instr, out_pc);
    end
    tests++;
    if (imem_en !== 1'b0 || imem_addr !== 16'h0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_imem got en=%b addr=%h halted=%b want 0 0000 0", imem_en, imem_addr, halted);
    end
    tests++;
    if (w_imem_addr !== 16'hFFFE || w_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc_param got addr=%h valid=%b want fffe 0", w_imem_addr, w_out_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream;
    int t_issue;
    int t_valid;
    do_reset();
    out_ready = 1'b1;
    exp_pc = 16'h0;
    t_issue = -1;
    t_valid = -1;
    for (int i = 0; i < 8 && t_valid < 0; i++) begin
      #1;
      if (imem_en && t_issue < 0) t_issue = cyc;
      if (out_valid) t_valid = cyc;
      else tick();
    end
    tests++;
    if (t_issue < 0 || t_valid < 0 || (t_valid - t_issue) != 2) begin
      fails++;
      $display("FAIL stream_latency got issue=%0d valid=%0d want valid-issue=2", t_issue, t_valid);
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== 16'h1000 + exp_pc) begin
        fails++;
        $display("FAIL stream_data got v=%b pc=%h instr=%h want 1 %h %h", out_valid, out_pc, out_instr, exp_pc, 16'h1000 + exp_pc);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] held_pc;
    logic [15:0] held_instr;
    out_ready = 1'b0;
    #1;
    held_pc    = out_pc;
    held_instr = out_instr;
    tests++;
    if (held_pc !== exp_pc) begin
      fails++;
      $display("FAIL bp_head got pc=%h want %h", held_pc, exp_pc);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin
        fails++;
        $display("FAIL bp_stable got v=%b pc=%h instr=%h want 1 %h %h", out_valid, out_pc, out_instr, held_pc, held_instr);
      end
      tests++;
      if (imem_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_no_issue got imem_en=%b want 0", imem_en);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== 16'h1000 + exp_pc) begin
        fails++;
        $display("FAIL bp_resume got v=%b pc=%h instr=%h want 1 %h %h", out_valid, out_pc, out_instr, exp_pc, 16'h1000 + exp_pc);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_random_ready;
    logic        prev_stall;
    logic [15:0] prev_pc;
    logic [15:0] prev_instr;
    prev_stall = 1'b0;
    prev_pc    = 16'h0;
    prev_instr = 16'h0;
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          fails++;
          $display("FAIL rr_hold got v=%b pc=%h instr=%h want 1 %h %h", out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== 16'h1000 + exp_pc) begin
          fails++;
          $display("FAIL rr_data got pc=%h instr=%h want %h %h", out_pc, out_instr, exp_pc, 16'h1000 + exp_pc);
        end
        exp_pc++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      tick();
    end
  endtask

  task automatic test_branch;
    do_reset();
    out_ready = 1'b1;
    exp_pc = 16'h0;
    for (int i = 0; i < 20 && exp_pc != 16'd4; i++) begin
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (out_pc !== exp_pc) begin
          fails++;
          $display("FAIL br_pre got pc=%h want %h", out_pc, exp_pc);
        end
        exp_pc++;
      end
      tick();
    end
    // Cycle t: redirect while PCs 4.. are buffered / in flight.
    out_ready = 1'b0;
    br_en     = 1'b1;
    br_target = 16'h0020;
    #1;
    tick();
    br_en     = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 16'h0020) begin
      fails++;
      $display("FAIL br_t1 got v=%b en=%b addr=%h want 0 1 0020", out_valid, imem_en, imem_addr);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL br_t2 got v=%b want 0", out_valid);
    end
    tick();
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0020 || out_instr !== 16'h1020) begin
      fails++;
      $display("FAIL br_t3 got v=%b pc=%h instr=%h want 1 0020 1020", out_valid, out_pc, out_instr);
    end
    exp_pc = 16'h0021;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== 16'h1000 + exp_pc) begin
        fails++;
        $display("FAIL br_after got v=%b pc=%h want 1 %h", out_valid, out_pc, exp_pc);
      end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int t2;
    int t_valid;
    out_ready = 1'b1;
    br_en     = 1'b1;
    br_target = 16'h0100;
    #1;
    tick();
    br_target = 16'h0200;
    t2 = cyc;
    #1;
    tick();
    br_en = 1'b0;
    t_valid = -1;
    for (int i = 0; i < 10 && t_valid < 0; i++) begin
      #1;
      if (out_valid) t_valid = cyc;
      else tick();
    end
    tests++;
    if (t_valid < 0 || (t_valid - t2) != 3 || out_pc !== 16'h0200 || out_instr !== 16'h1200) begin
      fails++;
      $display("FAIL b2b got dt=%0d pc=%h instr=%h want 3 0200 1200", t_valid - t2, out_pc, out_instr);
    end
    tick();
  endtask

  task automatic test_random_branch;
    logic        prev_br;
    logic [15:0] prev_tgt;
    do_reset();
    exp_pc   = 16'h0;
    prev_br  = 1'b0;
    prev_tgt = 16'h0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      br_en     = ($urandom_range(0, 9) == 0);
      br_target = 16'($urandom_range(0, 65535));
      #1;
      if (prev_br) begin
        tests++;
        if (out_valid !== 1'b0 || imem_addr !== prev_tgt) begin
          fails++;
          $display("FAIL rb_flush got v=%b addr=%h want 0 %h", out_valid, imem_addr, prev_tgt);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== 16'h1000 + exp_pc) begin
          fails++;
          $display("FAIL rb_data got pc=%h instr=%h want %h %h", out_pc, out_instr, exp_pc, 16'h1000 + exp_pc);
        end
        exp_pc++;
      end
      if (br_en) exp_pc = br_target;
      prev_br  = br_en;
      prev_tgt = br_target;
      tick();
    end
    br_en = 1'b0;
  endtask

  task automatic test_halt;
    logic got;
    do_reset();
    out_ready = 1'b1;
    exp_pc = 16'h0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid && out_ready) exp_pc++;
      tick();
    end
    halt      = 1'b1;
    br_en     = 1'b1;
    br_target = 16'h0040;
    #1;
    tests++;
    if (imem_en !== 1'b0 || (out_valid && out_pc !== exp_pc)) begin
      fails++;
      $display("FAIL halt_t0 got en=%b pc=%h want 0 %h", imem_en, out_pc, exp_pc);
    end
    tick();
    halt  = 1'b0;
    br_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      br_en     = ($urandom_range(0, 3) == 0);
      br_target = 16'($urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 1) != 0);
      #1;
      tests++;
      if (halted !== 1'b1 || out_valid !== 1'b0 || imem_en !== 1'b0) begin
        fails++;
        $display("FAIL halt_hold got halted=%b v=%b en=%b want 1 0 0", halted, out_valid, imem_en);
      end
      tick();
    end
    br_en     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_clear got halted=%b want 0", halted);
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (out_valid) got = 1'b1;
      else tick();
    end
    tests++;
    if (!got || out_pc !== 16'h0 || out_instr !== 16'h1000) begin
      fails++;
      $display("FAIL halt_restart got seen=%b pc=%h instr=%h want 1 0000 1000", got, out_pc, out_instr);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic got;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_instr !== 16'h0) begin
      fails++;
      $display("FAIL rstmid_empty got v=%b pc=%h instr=%h want 0 0000 0000", out_valid, out_pc, out_instr);
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (out_valid) got = 1'b1;
      else tick();
    end
    tests++;
    if (!got || out_pc !== 16'h0 || out_instr !== 16'h1000) begin
      fails++;
      $display("FAIL rstmid_first got seen=%b pc=%h instr=%h want 1 0000 1000", got, out_pc, out_instr);
    end
    tick();
  endtask

  task automatic test_wrap;
    logic [15:0] wexp [4];
    int          idx;
    wexp[0] = 16'hFFFE;
    wexp[1] = 16'hFFFF;
    wexp[2] = 16'h0000;
    wexp[3] = 16'h0001;
    do_reset();
    w_out_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 12 && idx < 4; i++) begin
      #1;
      if (w_out_valid) begin
        tests++;
        if (w_out_pc !== wexp[idx] || w_out_instr !== 16'h1000 + wexp[idx]) begin
          fails++;
          $display("FAIL wrap_pc got pc=%h instr=%h want %h %h", w_out_pc, w_out_instr, wexp[idx], 16'h1000 + wexp[idx]);
        end
        idx++;
      end
      tick();
    end
    tests++;
    if (idx != 4) begin
      fails++;
      $display("FAIL wrap_timeout got %0d deliveries want 4", idx);
    end
    w_out_ready = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    exp_pc      = 16'h0;
    reset       = 1'b1;
    br_en       = 1'b0;
    br_target   = 16'h0;
    halt        = 1'b0;
    out_ready   = 1'b0;
    imem_data   = 16'h0;
    w_imem_data = 16'h0;
    w_br_en     = 1'b0;
    w_br_target = 16'h0;
    w_halt      = 1'b0;
    w_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_branch();
    test_back_to_back();
    test_random_branch();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
